perceptron_trainer: RTL
=======================

// Module: perceptron_trainer
// PURPOSE
//   Parametrised single-neuron perceptron with on-line training. Accepts one labelled
//   sample per handshake and computes the MAC serially, one input per cycle.
//   It applies a step activation and, in train mode, performs a saturating
//   weight/bias update on a misprediction.
//   Sits between the sample source (switches/host) and uo_out, and is the
//   multi-input, trainable successor to the fixed 2-input perceptron.
// PARAMETERS
//   N_IN      2        number of inputs per sample (>=1)
//   X_W       4        signed width of each input element
//   W_W       8        signed width of each weight and of the bias
//   LR_SHIFT  0        learning rate = 2^-LR_SHIFT; update term is x[i] >>> LR_SHIFT
//   CNT_W     16       width of the saturating error counter
//   (local) ACC_W = W_W + X_W + $clog2(N_IN+1); SEL_W = $clog2(N_IN+1)
// PORTS
//   clk        in   1              clock
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              sample present
//   in_ready   out  1              block can accept a sample
//   x_in       in   N_IN*X_W       packed signed inputs; x[i] = x_in[i*X_W +: X_W]
//   label      in   1              target class (0/1)
//   train      in   1              1 = update on error, 0 = inference only
//   out_valid  out  1              1-cycle pulse: y_out/err valid
//   y_out      out  1              activation result, held until next out_valid
//   err        out  1              train && (y_out != label), held with y_out
//   w_wr_en    in   1              preload weight w_sel with w_wr_data (IDLE only)
//   w_wr_data  in   W_W            preload value
//   w_sel      in   SEL_W          weight select; index N_IN = bias
//   w_rd       out  W_W            combinational readback of w_sel; 0 if out of range
//   err_cnt    out  CNT_W          count of training errors, saturating at all-ones
//   clr_cnt    in   1              synchronous clear of err_cnt
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; all weights, bias, acc and err_cnt = 0;
//     out_valid=0, y_out=0, err=0. Reset mid-operation aborts and drops the sample;
//     no partial update or out_valid follows.
//   FSM states: IDLE -> MAC -> ACT -> (UPDATE) -> DONE -> IDLE.
//   IDLE: in_ready = !w_wr_en. On in_valid&&in_ready, capture x_in/label/train,
//     set acc=sign-extended bias, set i=0 -> MAC. If w_wr_en: write w_sel (if <= N_IN) and
//     accept no sample that cycle. w_wr_en outside IDLE is ignored.
//   MAC: N_IN cycles; each cycle acc += w[i]*x[i] (signed full-precision product, sign-extended
//     to ACC_W, cannot overflow); i++. The cycle that processes i=N_IN-1 moves to ACT.
//   ACT: y = (acc > 0) signed, strictly positive; e = train && (y != label).
//     If e: err_cnt++ (saturating) -> UPDATE; else -> DONE.
//   UPDATE (single cycle): d = label ? +1 : -1. For all i: w[i] = sat(w[i] + d*(x[i]>>>LR_SHIFT));
//     bias = sat(bias + d). sat clamps to [-2^(W_W-1), 2^(W_W-1)-1]. -> DONE.
//   DONE: out_valid=1 for exactly this cycle; y_out/err registered; -> IDLE.
//   Latency from accept edge T: out_valid in cycle T+N_IN+2 without update and
//     T+N_IN+3 with update. Updated weights are visible on w_rd in the DONE cycle.
//   in_ready=0 in every non-IDLE state; samples are never queued or dropped silently.
//   clr_cnt wins over a simultaneous increment. err_cnt holds at 2^CNT_W-1.
//   y_out and err change only when out_valid is asserted.
// TESTING (N_IN=2, X_W=4, W_W=8, LR_SHIFT=0 unless stated)
//   1 Reset: rst_n low -> w_rd=0 for sel 0..2, in_ready=1, out_valid=0, err_cnt=0.
//   2 Train err: zero weights, x=(2,3), label=1, train=1 -> acc=0, y=0, err=1, out_valid at T+5;
//     w0=2, w1=3, bias=1, err_cnt=1.
//   3 Infer: then x=(2,3), train=0 -> acc=14, y=1, err=0, out_valid at T+4, weights unchanged.
//   4 Saturation: preload w0=127, w1=-128, bias=0; x=(7,7), label=1, train=1 -> acc=-7, y=0;
//     result w0=127, w1=-121, bias=1.
//   5 Reset mid-MAC: accept a sample, pull rst_n low at T+2 -> no out_valid; weights 0; IDLE.
//   6 Backpressure/counter: hold in_valid through busy -> exactly one accept per IDLE visit;
//     clr_cnt with a simultaneous error -> err_cnt=0.

Source files
------------

// File: rtl/perceptron_trainer_if.sv
`default_nettype none
// ============================================================================
// Module  : perceptron_trainer_if
// Purpose : sample-in / result-out handshake bundle for perceptron_trainer
// Revision: 1.0
// ============================================================================
interface perceptron_trainer_if #(
  parameter int N_IN = 2,
  parameter int X_W  = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*X_W-1:0]    x_in;
  logic                   label;
  logic                   train;
  logic                   out_valid;
  logic                   y_out;
  logic                   err;

  modport master (
    output in_valid, x_in, label, train,
    input  in_ready, out_valid, y_out, err
  );

  modport slave (
    input  in_valid, x_in, label, train,
    output in_ready, out_valid, y_out, err
  );
endinterface
`default_nettype wire

// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module  : perceptron_trainer
// Purpose : single-neuron perceptron, serial MAC, step activation, on-line training
// Revision: 1.0
// ============================================================================
module perceptron_trainer #(
  parameter  int N_IN     = 2,
  parameter  int X_W      = 4,
  parameter  int W_W      = 8,
  parameter  int LR_SHIFT = 0,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = $clog2(N_IN + 1),
  localparam int ACC_W    = W_W + X_W + $clog2(N_IN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  perceptron_trainer_if.slave  s_if,
  input  logic                 w_wr_en,
  input  logic [W_W-1:0]       w_wr_data,
  input  logic [SEL_W-1:0]     w_sel,
  output logic [W_W-1:0]       w_rd,
  output logic [CNT_W-1:0]     err_cnt,
  input  logic                 clr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_ACT    = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0]        LAST_IDX = SEL_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] W_MAX    = {{(ACC_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] W_MIN    = {{(ACC_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ONE      = ACC_W'(1);

  state_t                  state_q, state_d;
  // Index N_IN of the weight array holds the bias.
  logic signed [W_W-1:0]   w_q [N_IN+1];
  logic signed [W_W-1:0]   w_d [N_IN+1];
  logic signed [X_W-1:0]   x_q [N_IN];
  logic signed [X_W-1:0]   x_d [N_IN];
  logic                    label_q, label_d;
  logic                    train_q, train_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic                    y_pend_q, y_pend_d;
  logic                    y_q, y_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [W_W-1:0]   w_cur;
  logic signed [X_W-1:0]   x_cur;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] upd;
  logic                    y_calc;
  logic                    e_calc;
  logic                    cnt_inc;

  function automatic logic signed [ACC_W-1:0] ext_w(input logic signed [W_W-1:0] v);
    ext_w = {{(ACC_W-W_W){v[W_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_x(input logic signed [X_W-1:0] v);
    ext_x = {{(ACC_W-X_W){v[X_W-1]}}, v};
  endfunction

  function automatic logic signed [W_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > W_MAX) begin
      sat = W_MAX[W_W-1:0];
    end else if (v < W_MIN) begin
      sat = W_MIN[W_W-1:0];
    end else begin
      sat = v[W_W-1:0];
    end
  endfunction

  // Operand select for the current MAC step; products are formed at full accumulator width.
  always_comb begin
    w_cur = '0;
    x_cur = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == SEL_W'(i)) begin
        w_cur = w_q[i];
        x_cur = x_q[i];
      end
    end
    prod = ext_w(w_cur) * ext_x(x_cur);
  end

  assign y_calc  = !acc_q[ACC_W-1] && (acc_q != '0);
  assign e_calc  = train_q && (y_calc != label_q);
  assign cnt_inc = (state_q == S_ACT) && e_calc;

  always_comb begin
    w_rd = '0;
    for (int i = 0; i <= N_IN; i++) begin
      if (w_sel == SEL_W'(i)) begin
        w_rd = w_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    x_d      = x_q;
    label_d  = label_q;
    train_d  = train_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    y_pend_d = y_pend_q;
    y_d      = y_q;
    err_d    = err_q;
    upd      = '0;

    case (state_q)
      S_IDLE: begin
        if (w_wr_en) begin
          for (int i = 0; i <= N_IN; i++) begin
            if (w_sel == SEL_W'(i)) begin
              w_d[i] = w_wr_data;
            end
          end
        end else if (s_if.in_valid) begin
          for (int i = 0; i < N_IN; i++) begin
            x_d[i] = s_if.x_in[i*X_W +: X_W];
          end
          label_d = s_if.label;
          train_d = s_if.train;
          acc_d   = ext_w(w_q[N_IN]);
          idx_d   = '0;
          state_d = S_MAC;
        end
      end

      S_MAC: begin
        acc_d = acc_q + prod;
        idx_d = idx_q + SEL_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_ACT;
        end
      end

      S_ACT: begin
        // Results are only published on entry to DONE so y_out/err never move early.
        if (e_calc) begin
          y_pend_d = y_calc;
          state_d  = S_UPDATE;
        end else begin
          y_d     = y_calc;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      S_UPDATE: begin
        for (int i = 0; i < N_IN; i++) begin
          upd    = ext_x(x_q[i] >>> LR_SHIFT);
          w_d[i] = sat(label_q ? (ext_w(w_q[i]) + upd) : (ext_w(w_q[i]) - upd));
        end
        w_d[N_IN] = sat(label_q ? (ext_w(w_q[N_IN]) + ONE) : (ext_w(w_q[N_IN]) - ONE));
        y_d       = y_pend_q;
        err_d     = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int i = 0; i <= N_IN; i++) begin
        w_q[i] <= '0;
      end
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
      end
      label_q  <= 1'b0;
      train_q  <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      y_pend_q <= 1'b0;
      y_q      <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      x_q      <= x_d;
      label_q  <= label_d;
      train_q  <= train_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      y_pend_q <= y_pend_d;
      y_q      <= y_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_if.in_ready  = (state_q == S_IDLE) && !w_wr_en;
  assign s_if.out_valid = (state_q == S_DONE);
  assign s_if.y_out     = y_q;
  assign s_if.err       = err_q;
  assign err_cnt        = cnt_q;

endmodule
`default_nettype wire
